// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control definitions: stall vector layout and
// the halt/drain sequencer states.
package pipe_ctrl_pkg;

    localparam int STALL_WIDTH = 4;

    localparam int STALL_PC = 0;
    localparam int STALL_IF = 1;
    localparam int STALL_ID = 2;
    localparam int STALL_EX = 3;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } ctrl_state_e;

endpackage

// File: rtl/pipe_ctrl.sv
// Central pipeline sequencer: stall vector, redirect arbitration,
// interrupt latch and debug halt/resume handshake.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_ADDR = 32'h0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ex_busy_i,
    input  logic                   jump_req_i,
    input  logic [31:0]            jump_addr_i,
    input  logic                   int_req_i,
    input  logic [31:0]            int_addr_i,
    output logic                   int_ack_o,
    input  logic                   dbg_halt_req_i,
    input  logic                   dbg_resume_req_i,
    output logic                   dbg_halted_o,
    output logic [STALL_WIDTH-1:0] stall_o,
    output logic                   flush_o,
    output logic [31:0]            flush_addr_o
);

    ctrl_state_e state_q;
    ctrl_state_e state_d;
    logic        int_pend_q;
    logic [31:0] int_addr_q;
    logic        int_take;

    assign int_take = int_pend_q && (state_q == RUN) && !ex_busy_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN: begin
                if (dbg_halt_req_i) state_d = DRAIN;
            end
            DRAIN: begin
                if (!ex_busy_i) state_d = HALTED;
            end
            HALTED: begin
                if (dbg_resume_req_i && !dbg_halt_req_i) state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    // A new request beats a same-cycle take: latest vector stays pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            int_pend_q <= 1'b0;
            int_addr_q <= 32'h0;
        end else if (int_req_i) begin
            int_pend_q <= 1'b1;
            int_addr_q <= int_addr_i;
        end else if (int_take) begin
            int_pend_q <= 1'b0;
        end
    end

    always_comb begin
        stall_o = '0;
        unique case (state_q)
            RUN: begin
                stall_o[STALL_PC] = ex_busy_i;
                stall_o[STALL_IF] = ex_busy_i;
                stall_o[STALL_ID] = ex_busy_i;
            end
            DRAIN: begin
                stall_o[STALL_PC] = 1'b1;
                stall_o[STALL_IF] = 1'b1;
                stall_o[STALL_ID] = 1'b1;
            end
            HALTED: begin
                stall_o = '1;
            end
            default: stall_o = '0;
        endcase
    end

    always_comb begin
        flush_o      = 1'b0;
        flush_addr_o = RESET_ADDR;
        if (int_take) begin
            flush_o      = 1'b1;
            flush_addr_o = int_addr_q;
        end else if (jump_req_i && (state_q != HALTED)) begin
            flush_o      = 1'b1;
            flush_addr_o = jump_addr_i;
        end
    end

    assign int_ack_o    = int_take;
    assign dbg_halted_o = (state_q == HALTED);

    a_no_jump_while_busy: assert property (
        @(posedge clk) disable iff (!rst_n) !(jump_req_i && ex_busy_i)
    );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed vector table, hand-written halt and
// reset sequences, then randomized traffic against a reference model.
module tb_pipe_ctrl;
    import pipe_ctrl_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        ex_busy_i;
    logic        jump_req_i;
    logic [31:0] jump_addr_i;
    logic        int_req_i;
    logic [31:0] int_addr_i;
    logic        int_ack_o;
    logic        dbg_halt_req_i;
    logic        dbg_resume_req_i;
    logic        dbg_halted_o;
    logic [STALL_WIDTH-1:0] stall_o;
    logic        flush_o;
    logic [31:0] flush_addr_o;

    int checks;
    int errors;

    pipe_ctrl #(.RESET_ADDR(32'h0)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .ex_busy_i        (ex_busy_i),
        .jump_req_i       (jump_req_i),
        .jump_addr_i      (jump_addr_i),
        .int_req_i        (int_req_i),
        .int_addr_i       (int_addr_i),
        .int_ack_o        (int_ack_o),
        .dbg_halt_req_i   (dbg_halt_req_i),
        .dbg_resume_req_i (dbg_resume_req_i),
        .dbg_halted_o     (dbg_halted_o),
        .stall_o          (stall_o),
        .flush_o          (flush_o),
        .flush_addr_o     (flush_addr_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        busy;
        logic        jreq;
        logic [31:0] jaddr;
        logic        ireq;
        logic [31:0] iaddr;
        logic        hreq;
        logic        rreq;
        logic [3:0]  e_stall;
        logic        e_flush;
        logic [31:0] e_faddr;
        logic        e_ack;
        logic        e_halted;
    } vec_t;

    vec_t vecs [26];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] e_stall,
                           input logic e_flush, input logic [31:0] e_faddr,
                           input logic e_ack, input logic e_halted);
        chk({tag, ".stall"},  32'(stall_o),      32'(e_stall));
        chk({tag, ".flush"},  32'(flush_o),      32'(e_flush));
        chk({tag, ".faddr"},  flush_addr_o,      e_faddr);
        chk({tag, ".ack"},    32'(int_ack_o),    32'(e_ack));
        chk({tag, ".halted"}, 32'(dbg_halted_o), 32'(e_halted));
    endtask

    task automatic drive(input logic busy, input logic jreq,
                         input logic [31:0] jaddr, input logic ireq,
                         input logic [31:0] iaddr, input logic hreq,
                         input logic rreq);
        ex_busy_i        = busy;
        jump_req_i       = jreq;
        jump_addr_i      = jaddr;
        int_req_i        = ireq;
        int_addr_i       = iaddr;
        dbg_halt_req_i   = hreq;
        dbg_resume_req_i = rreq;
        @(negedge clk);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        ex_busy_i = 0; jump_req_i = 0; jump_addr_i = 0;
        int_req_i = 0; int_addr_i = 0;
        dbg_halt_req_i = 0; dbg_resume_req_i = 0;
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
    endtask

    function automatic vec_t mk(input logic busy, input logic jreq,
                                input logic [31:0] jaddr, input logic ireq,
                                input logic [31:0] iaddr, input logic hreq,
                                input logic rreq, input logic [3:0] es,
                                input logic ef, input logic [31:0] ea,
                                input logic ek, input logic eh);
        vec_t v;
        v.busy = busy; v.jreq = jreq; v.jaddr = jaddr;
        v.ireq = ireq; v.iaddr = iaddr; v.hreq = hreq; v.rreq = rreq;
        v.e_stall = es; v.e_flush = ef; v.e_faddr = ea;
        v.e_ack = ek; v.e_halted = eh;
        return v;
    endfunction

    // reference model state for the random phase
    bit          m_drain;
    bit          m_halted;
    bit          m_pend;
    logic [31:0] m_vec;

    initial begin
        checks = 0;
        errors = 0;
        ex_busy_i = 0; jump_req_i = 0; jump_addr_i = 0;
        int_req_i = 0; int_addr_i = 0;
        dbg_halt_req_i = 0; dbg_resume_req_i = 0;
        rst_n = 1'b0;
        #1;
        chk_all("reset", 4'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        #11;
        rst_n = 1'b1;

        //            busy jreq jaddr         ireq iaddr        h  r   stall flush faddr        ack halted
        vecs[0]  = mk(0, 0, 32'h0,   0, 32'h0,   0, 0, 4'h0, 0, 32'h0,   0, 0);
        vecs[1]  = mk(0, 1, 32'h120, 0, 32'h0,   0, 0, 4'h0, 1, 32'h120, 0, 0);
        vecs[2]  = mk(0, 0, 32'h0,   0, 32'h0,   0, 0, 4'h0, 0, 32'h0,   0, 0);
        vecs[3]  = mk(1, 0, 32'h0,   1, 32'h80,  0, 0, 4'h7, 0, 32'h0,   0, 0);
        vecs[4]  = mk(1, 0, 32'h0,   0, 32'h0,   0, 0, 4'h7, 0, 32'h0,   0, 0);
        vecs[5]  = mk(1, 0, 32'h0,   0, 32'h0,   0, 0, 4'h7, 0, 32'h0,   0, 0);
        vecs[6]  = mk(1, 0, 32'h0,   0, 32'h0,   0, 0, 4'h7, 0, 32'h0,   0, 0);
        vecs[7]  = mk(1, 0, 32'h0,   0, 32'h0,   0, 0, 4'h7, 0, 32'h0,   0, 0);
        vecs[8]  = mk(0, 0, 32'h0,   0, 32'h0,   0, 0, 4'h0, 1, 32'h80,  1, 0);
        vecs[9]  = mk(0, 0, 32'h0,   0, 32'h0,   0, 0, 4'h0, 0, 32'h0,   0, 0);
        vecs[10] = mk(0, 0, 32'h0,   1, 32'h80,  0, 0, 4'h0, 0, 32'h0,   0, 0);
        vecs[11] = mk(0, 1, 32'h200, 0, 32'h0,   0, 0, 4'h0, 1, 32'h80,  1, 0);
        vecs[12] = mk(0, 0, 32'h0,   0, 32'h0,   0, 0, 4'h0, 0, 32'h0,   0, 0);
        vecs[13] = mk(1, 0, 32'h0,   0, 32'h0,   1, 0, 4'h7, 0, 32'h0,   0, 0);
        vecs[14] = mk(1, 0, 32'h0,   0, 32'h0,   1, 0, 4'h7, 0, 32'h0,   0, 0);
        vecs[15] = mk(1, 0, 32'h0,   0, 32'h0,   1, 0, 4'h7, 0, 32'h0,   0, 0);
        vecs[16] = mk(0, 0, 32'h0,   0, 32'h0,   1, 0, 4'h7, 0, 32'h0,   0, 0);
        vecs[17] = mk(0, 0, 32'h0,   0, 32'h0,   1, 0, 4'hF, 0, 32'h0,   0, 1);
        vecs[18] = mk(0, 0, 32'h0,   0, 32'h0,   0, 1, 4'hF, 0, 32'h0,   0, 1);
        vecs[19] = mk(0, 0, 32'h0,   0, 32'h0,   0, 0, 4'h0, 0, 32'h0,   0, 0);
        vecs[20] = mk(0, 0, 32'h0,   0, 32'h0,   1, 0, 4'h0, 0, 32'h0,   0, 0);
        vecs[21] = mk(0, 1, 32'h300, 0, 32'h0,   1, 1, 4'h7, 1, 32'h300, 0, 0);
        vecs[22] = mk(0, 0, 32'h0,   0, 32'h0,   1, 1, 4'hF, 0, 32'h0,   0, 1);
        vecs[23] = mk(0, 1, 32'h400, 0, 32'h0,   0, 0, 4'hF, 0, 32'h0,   0, 1);
        vecs[24] = mk(0, 0, 32'h0,   0, 32'h0,   0, 1, 4'hF, 0, 32'h0,   0, 1);
        vecs[25] = mk(0, 0, 32'h0,   0, 32'h0,   0, 0, 4'h0, 0, 32'h0,   0, 0);

        for (int i = 0; i < 26; i++) begin
            drive(vecs[i].busy, vecs[i].jreq, vecs[i].jaddr, vecs[i].ireq,
                  vecs[i].iaddr, vecs[i].hreq, vecs[i].rreq);
            chk_all($sformatf("vec%0d", i), vecs[i].e_stall, vecs[i].e_flush,
                    vecs[i].e_faddr, vecs[i].e_ack, vecs[i].e_halted);
            tick();
        end

        // interrupt arriving while halted is held until resume
        drive(0, 0, 32'h0, 0, 32'h0, 1, 0);
        chk_all("ih.run", 4'h0, 0, 32'h0, 0, 0);
        tick();
        drive(0, 0, 32'h0, 0, 32'h0, 1, 0);
        chk_all("ih.drain", 4'h7, 0, 32'h0, 0, 0);
        tick();
        drive(0, 0, 32'h0, 1, 32'h1c0, 1, 0);
        chk_all("ih.halt_req", 4'hF, 0, 32'h0, 0, 1);
        tick();
        drive(0, 0, 32'h0, 0, 32'h0, 0, 1);
        chk_all("ih.resume", 4'hF, 0, 32'h0, 0, 1);
        tick();
        idle();
        chk_all("ih.take", 4'h0, 1, 32'h1c0, 1, 0);
        tick();
        idle();
        chk_all("ih.after", 4'h0, 0, 32'h0, 0, 0);
        tick();

        // reset while halted with an interrupt pending
        drive(0, 0, 32'h0, 0, 32'h0, 1, 0);
        tick();
        drive(0, 0, 32'h0, 0, 32'h0, 1, 0);
        tick();
        drive(0, 0, 32'h0, 1, 32'h2c0, 1, 0);
        chk_all("rh.halted", 4'hF, 0, 32'h0, 0, 1);
        tick();
        dbg_halt_req_i = 0;
        int_req_i = 0;
        rst_n = 1'b0;
        #1;
        chk_all("rh.async", 4'h0, 0, 32'h0, 0, 0);
        #2;
        rst_n = 1'b1;
        idle();
        chk_all("rh.nopend", 4'h0, 0, 32'h0, 0, 0);
        tick();

        // randomized traffic against the reference model
        do_reset();
        m_drain = 0; m_halted = 0; m_pend = 0; m_vec = 32'h0;
        begin
            logic        hreq_lvl;
            hreq_lvl = 1'b0;
            for (int n = 0; n < 3000; n++) begin
                logic        busy, jreq, ireq, rreq, take, running, jeff;
                logic [31:0] jaddr, iaddr, e_addr;
                logic [3:0]  e_stall;
                busy  = ($urandom_range(0, 2) == 0);
                jreq  = !busy && ($urandom_range(0, 3) == 0);
                jaddr = $urandom & 32'hFFFF_FFFC;
                ireq  = ($urandom_range(0, 5) == 0);
                iaddr = $urandom & 32'hFFFF_FFFC;
                if ($urandom_range(0, 11) == 0) hreq_lvl = ~hreq_lvl;
                rreq  = ($urandom_range(0, 3) == 0);

                running = !m_drain && !m_halted;
                take    = m_pend && running && !busy;
                jeff    = jreq && !m_halted;
                if (m_halted)
                    e_stall = 4'hF;
                else if (m_drain || busy)
                    e_stall = 4'h7;
                else
                    e_stall = 4'h0;
                e_addr = take ? m_vec : (jeff ? jaddr : 32'h0);

                drive(busy, jreq, jaddr, ireq, iaddr, hreq_lvl, rreq);
                chk_all($sformatf("rnd%0d", n), e_stall, take || jeff,
                        e_addr, take, m_halted);
                tick();

                if (ireq) begin
                    m_pend = 1;
                    m_vec  = iaddr;
                end else if (take) begin
                    m_pend = 0;
                end
                if (running && hreq_lvl)
                    m_drain = 1;
                else if (m_drain && !busy) begin
                    m_drain  = 0;
                    m_halted = 1;
                end else if (m_halted && rreq && !hreq_lvl)
                    m_halted = 0;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central pipeline sequencer. It generates the per-stage `stall_o` vector and the `flush_o`/`flush_addr_o` redirect that drive every inter-stage register (pc, if/id, id/ex).
- Arbitrates redirect sources: external interrupt (latched, deferred while EX is busy) over EX branch/jump.
- Runs the debug halt/resume handshake, draining EX before freezing the core.
- Outputs are combinational from inputs and registered state, so a redirect takes effect at the next clock edge.

Parameters:
- `STALL_WIDTH`, 4, width of the stall vector (from shared package).
- `RESET_ADDR`, 32'h0, value of `flush_addr_o` when no redirect is active.

Ports:
- `clk`  input  1  clock
- `rst_n`  input  1  asynchronous active-low reset
- `ex_busy_i`  input  1  EX executing a multi-cycle op (mul/div); EX holds itself
- `jump_req_i`  input  1  EX redirect request (branch taken/jump), single-cycle
- `jump_addr_i`  input  32  EX redirect target
- `int_req_i`  input  1  CLINT interrupt request pulse
- `int_addr_i`  input  32  trap vector, valid with `int_req_i`
- `int_ack_o`  output  1  one-cycle pulse: latched interrupt taken this cycle
- `dbg_halt_req_i`  input  1  debug halt request (level)
- `dbg_resume_req_i`  input  1  debug resume request (pulse)
- `dbg_halted_o`  output  1  core fully halted
- `stall_o`  output  `STALL_WIDTH`  per-stage hold, bit indices `STALL_PC`=0, `STALL_IF`=1, `STALL_ID`=2, `STALL_EX`=3
- `flush_o`  output  1  kill front-end stages and redirect fetch
- `flush_addr_o`  output  32  fetch redirect address

Behaviour:
- Reset (async, `rst_n` low):
  - state=RUN, `int_pend_q`=0, `int_addr_q`=0.
  - All outputs 0, except `flush_addr_o`=`RESET_ADDR`.
- States:
  - RUN: normal operation.
  - DRAIN: halt requested; front end frozen; EX allowed to finish.
  - HALTED: everything frozen.
- Transitions:
  - RUN -> DRAIN when `dbg_halt_req_i`=1.
  - DRAIN -> HALTED when `ex_busy_i`=0.
  - HALTED -> RUN when `dbg_resume_req_i`=1 and `dbg_halt_req_i`=0. If both are high, stay HALTED.
  - DRAIN ignores `dbg_resume_req_i`.
- Interrupt latch:
  - `int_req_i`=1 sets `int_pend_q`=1 and `int_addr_q`=`int_addr_i`.
  - A new `int_req_i` while already pending overwrites `int_addr_q` (latest vector wins).
  - `int_take` = `int_pend_q` & state==RUN & ~`ex_busy_i`.
  - When `int_take`: `int_ack_o`=1 for that cycle; `int_pend_q` clears next edge.
  - Same-cycle `int_take` and new `int_req_i`: the set wins; the pending bit stays 1 with the new address.
  - The pending interrupt is never taken in DRAIN or HALTED; it is retained across halt and taken in the first eligible RUN cycle after resume.
- Redirect (combinational):
  - `int_take`: `flush_o`=1, `flush_addr_o`=`int_addr_q` (priority over jump).
  - Else if `jump_req_i` and state!=HALTED: `flush_o`=1, `flush_addr_o`=`jump_addr_i`.
  - Else `flush_o`=0, `flush_addr_o`=`RESET_ADDR`.
  - `jump_req_i` with `ex_busy_i`=1 is illegal; an SVA assertion flags it.
- Stall (combinational):
  - RUN: `stall_o[PC..ID]`=`ex_busy_i`; `stall_o[EX]`=0.
  - DRAIN: `stall_o[PC..ID]`=1, `stall_o[EX]`=0.
  - HALTED: `stall_o`=all ones.
  - `flush_o` overrides the front-end stall at each stage register; `stall_o` is not masked here.
- `dbg_halted_o`=1 iff state==HALTED (registered, so valid the cycle after the DRAIN exit).
- A jump in the DRAIN->HALTED cycle is honoured (flush issued); fetch then holds the target.
- Reset mid-DRAIN or mid-HALTED returns to RUN and drops any pending interrupt.

Decomposition:
- Shared package (defines.sv): `STALL_WIDTH`, the `STALL_PC`/`IF`/`ID`/`EX` indices, and a `ctrl_state_e` enum {RUN, DRAIN, HALTED}.
- No sub-module: one FSM plus one interrupt-latch register set. Target size is roughly 150 lines.

Test Plan:
- Reset, idle inputs -> `stall_o`=4'b0000, `flush_o`=0, `flush_addr_o`=0, `dbg_halted_o`=0.
- `jump_req_i`=1, `jump_addr_i`=32'h0000_0120 -> same cycle `flush_o`=1, `flush_addr_o`=32'h120; next cycle `flush_o`=0.
- `ex_busy_i`=1 for 5 cycles, `int_req_i` pulse with 32'h0000_0080 in cycle 1:
  - `stall_o`=4'b0111 for cycles 1-5, no ack.
  - First cycle with `ex_busy_i`=0: `int_ack_o`=1, `flush_addr_o`=32'h80.
- Same cycle: pending interrupt (vector 32'h80) and jump to 32'h200 -> `flush_addr_o`=32'h80, `int_ack_o`=1.
- `dbg_halt_req_i`=1 with `ex_busy_i`=1 for 3 cycles:
  - `stall_o`=4'b0111 while draining.
  - Then `stall_o`=4'b1111, `dbg_halted_o`=1.
  - Drop halt, pulse resume -> RUN, `stall_o`=0.
- Interrupt pulse while HALTED -> no ack; after resume, `int_ack_o`=1 on the first RUN cycle. Assert `rst_n`=0 while HALTED -> immediately `stall_o`=0, `dbg_halted_o`=0.
